alu_mem_unit: RTL and testbench

- Execution-side datapath block for the multi-cycle RV32I core.
- Contains two independent functions:
  - a combinational RV32I integer ALU with branch comparator;
  - a Wishbone-style single-port word memory, usable as the 32-entry register file or as a small RAM.
- The core drives both interfaces directly. They share only i_clk and i_reset.

---
 rtl/alu_mem_unit_pkg.sv | 31 +++
 rtl/alu_mem_unit_if.sv | 30 +++
 rtl/alu_mem_unit_rv_alu.sv | 63 ++++++
 rtl/alu_mem_unit.sv | 101 ++++++++++
 tb/tb_alu_mem_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mem_unit_pkg.sv
// ----------------------------------------------------------------------------
// alu_mem_unit_pkg
// Shared definitions for the execution-side datapath block of the RV32I core:
//   - Wishbone bus widths used by alu_mem_unit_if and the memory.
//   - ALU funct3 encodings (ALU_*) and branch funct3 encodings (BR_*).
// ----------------------------------------------------------------------------
package alu_mem_unit_pkg;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = WB_DW / 8;

   // ALU funct3
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SR   = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   // Branch funct3 (010 and 011 are unused encodings)
   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/alu_mem_unit_if.sv
// ----------------------------------------------------------------------------
// alu_mem_unit_if
// Wishbone-style single-port memory bus between the core and alu_mem_unit.
//   master (core)  : drives i_wb_stb/we/addr/data/sel, receives o_wb_*.
//   slave  (memory): receives i_wb_*, drives o_wb_data/ack/stall.
// Signal names keep the i_/o_ prefixes as seen from the memory side.
// ----------------------------------------------------------------------------
interface alu_mem_unit_if;
   import alu_mem_unit_pkg::*;

   logic             i_wb_stb;
   logic             i_wb_we;
   logic [WB_AW-1:0] i_wb_addr;
   logic [WB_DW-1:0] i_wb_data;
   logic [WB_SW-1:0] i_wb_sel;
   logic [WB_DW-1:0] o_wb_data;
   logic             o_wb_ack;
   logic             o_wb_stall;

   modport master (
      output i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      input  o_wb_data, o_wb_ack, o_wb_stall
   );

   modport slave (
      input  i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      output o_wb_data, o_wb_ack, o_wb_stall
   );

endinterface

// File: rtl/alu_mem_unit_rv_alu.sv
// ----------------------------------------------------------------------------
// rv_alu
// Combinational RV32I integer ALU plus branch comparator.
//   a_i, b_i          : operands (rs1, rs2 or immediate)
//   op_i              : ALU funct3
//   sub_i             : subtract for ALU_ADD
//   arith_shift_i     : arithmetic right shift for ALU_SR
//   branch_op_i       : branch funct3, evaluated independently of op_i
//   y_o               : ALU result
//   will_branch_o     : branch condition true
// ----------------------------------------------------------------------------
module rv_alu
   import alu_mem_unit_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  op_i,
   input  logic        sub_i,
   input  logic        arith_shift_i,
   input  logic [2:0]  branch_op_i,
   output logic [31:0] y_o,
   output logic        will_branch_o
);

   logic [4:0] shamt;
   logic       lt_s;
   logic       lt_u;
   logic       eq;

   assign shamt = b_i[4:0];
   assign lt_s  = $signed(a_i) < $signed(b_i);
   assign lt_u  = a_i < b_i;
   assign eq    = a_i == b_i;

   always_comb begin
      y_o = '0;
      case (op_i)
         ALU_ADD:  y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
         ALU_SLL:  y_o = a_i << shamt;
         ALU_SLT:  y_o = {31'b0, lt_s};
         ALU_SLTU: y_o = {31'b0, lt_u};
         ALU_XOR:  y_o = a_i ^ b_i;
         ALU_SR:   y_o = arith_shift_i ? 32'($signed(a_i) >>> shamt) : (a_i >> shamt);
         ALU_OR:   y_o = a_i | b_i;
         ALU_AND:  y_o = a_i & b_i;
         default:  y_o = '0;
      endcase
   end

   always_comb begin
      will_branch_o = 1'b0;
      case (branch_op_i)
         BR_EQ:   will_branch_o = eq;
         BR_NE:   will_branch_o = ~eq;
         BR_LT:   will_branch_o = lt_s;
         BR_GE:   will_branch_o = ~lt_s;
         BR_LTU:  will_branch_o = lt_u;
         BR_GEU:  will_branch_o = ~lt_u;
         default: will_branch_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_mem_unit.sv
// ----------------------------------------------------------------------------
// alu_mem_unit
// Execution-side datapath block of the multi-cycle RV32I core:
//   - rv_alu: combinational ALU + branch comparator (i_alu_* / o_alu_*).
//   - single-port word memory on a Wishbone-style bus (wb, slave modport),
//     used as the register file or a small RAM. Every strobe is accepted,
//     ack follows one cycle later, read data is registered with the ack.
// Ports: i_clk, i_reset (synchronous, active-high), wb, ALU operands/results.
// MEM_FILE and MEM_DUMP_SIZE are kept for build compatibility; initial
// contents and dumps are handled by the simulation harness.
// ----------------------------------------------------------------------------
module alu_mem_unit
   import alu_mem_unit_pkg::*;
#(
   parameter int MEM_SIZE      = 32,
   parameter int MEM_DUMP_SIZE = 32,
   parameter     MEM_FILE      = "reg_file.txt",
   parameter bit HARDWIRE_X0   = 1'b1,
   parameter bit BYTE_ADDR     = 1'b0
)(
   input  logic               i_clk,
   input  logic               i_reset,
   alu_mem_unit_if.slave      wb,
   input  logic [31:0]        i_alu_a,
   input  logic [31:0]        i_alu_b,
   input  logic [2:0]         i_alu_op,
   input  logic               i_alu_sub,
   input  logic               i_alu_arith_shift,
   input  logic [2:0]         i_alu_branch_op,
   output logic [31:0]        o_alu_y,
   output logic               o_alu_will_branch
);

   localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

   logic [WB_DW-1:0] mem_q [MEM_SIZE];
   logic [WB_DW-1:0] rdata_q;
   logic             ack_q;
   logic             ack_d;

   logic [31:0]      word_addr;
   logic [IDX_W-1:0] idx;
   logic             idx_is_x0;
   logic             accept;
   logic             wr_en;
   logic [WB_SW-1:0] lane_we;

   // Out-of-range addresses wrap modulo MEM_SIZE.
   assign word_addr = BYTE_ADDR ? {2'b00, wb.i_wb_addr[31:2]} : wb.i_wb_addr;
   assign idx       = IDX_W'(word_addr % 32'(MEM_SIZE));
   assign idx_is_x0 = HARDWIRE_X0 && (idx == '0);

   assign accept = wb.i_wb_stb & ~i_reset;
   // Writes to x0 still complete on the bus but never reach the array.
   assign wr_en  = accept & wb.i_wb_we & ~idx_is_x0;
   assign ack_d  = wb.i_wb_stb;

   genvar gi;
   for (gi = 0; gi < WB_SW; gi++) begin : g_lane
      assign lane_we[gi] = wr_en & wb.i_wb_sel[gi];
   end

   always_ff @(posedge i_clk) begin
      for (int b = 0; b < WB_SW; b++) begin
         if (lane_we[b]) begin
            mem_q[idx][8*b +: 8] <= wb.i_wb_data[8*b +: 8];
         end
      end
   end

   // Read register only updates on reads, so o_wb_data holds across writes.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q <= ack_d;
         if (wb.i_wb_stb && !wb.i_wb_we) begin
            rdata_q <= idx_is_x0 ? '0 : mem_q[idx];
         end
      end
   end

   // Gating with i_reset cancels an ack that is already registered when reset
   // arrives, and forces outputs to zero for every cycle reset is high.
   assign wb.o_wb_ack   = ack_q & ~i_reset;
   assign wb.o_wb_data  = i_reset ? '0 : rdata_q;
   assign wb.o_wb_stall = 1'b0;

   rv_alu u_alu (
      .a_i           (i_alu_a),
      .b_i           (i_alu_b),
      .op_i          (i_alu_op),
      .sub_i         (i_alu_sub),
      .arith_shift_i (i_alu_arith_shift),
      .branch_op_i   (i_alu_branch_op),
      .y_o           (o_alu_y),
      .will_branch_o (o_alu_will_branch)
   );

endmodule

// File: tb/tb_alu_mem_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_mem_unit
// Scoreboard bench for alu_mem_unit: each bus transfer pushes its expected
// ack cycle and o_wb_data onto a queue; a negedge monitor pops on every ack.
// ALU and branch vectors are checked directly against constants.
// ----------------------------------------------------------------------------
module tb_alu_mem_unit;

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] data;
      logic        we;
      logic [31:0] addr;
   } sb_entry_t;

   logic        clk;
   logic        rst;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic        alu_sub;
   logic        alu_ars;
   logic [2:0]  br_op;
   logic [31:0] alu_y;
   logic        will_branch;

   int          checks;
   int          errors;
   logic [31:0] cyc;
   logic [31:0] mem_m [32];
   logic [31:0] last_rd;
   sb_entry_t   sb_q [$];

   alu_mem_unit_if wb_bus ();

   alu_mem_unit #(
      .MEM_SIZE      (32),
      .MEM_DUMP_SIZE (0),
      .MEM_FILE      (""),
      .HARDWIRE_X0   (1'b1),
      .BYTE_ADDR     (1'b0)
   ) dut (
      .i_clk             (clk),
      .i_reset           (rst),
      .wb                (wb_bus),
      .i_alu_a           (alu_a),
      .i_alu_b           (alu_b),
      .i_alu_op          (alu_op),
      .i_alu_sub         (alu_sub),
      .i_alu_arith_shift (alu_ars),
      .i_alu_branch_op   (br_op),
      .o_alu_y           (alu_y),
      .o_alu_will_branch (will_branch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Monitor: every ack must match the oldest outstanding transfer.
   always @(negedge clk) begin
      if (wb_bus.o_wb_ack === 1'b1) begin
         if (sb_q.size() == 0) begin
            check32("ack_spurious", 32'd1, 32'd0);
         end else begin
            sb_entry_t e;
            e = sb_q.pop_front();
            $display("TXN cyc=%0d %s addr=%08h o_wb_data=%08h exp=%08h",
                     cyc, e.we ? "WR" : "RD", e.addr, wb_bus.o_wb_data, e.data);
            check32("ack_cycle", cyc, e.cyc);
            check32(e.we ? "wr_data_hold" : "rd_data", wb_bus.o_wb_data, e.data);
            check32("stall", {31'b0, wb_bus.o_wb_stall}, 32'd0);
         end
      end
   end

   // Drive one strobe for one cycle; strobe stays high so calls can chain.
   task automatic wb_xfer(input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] sel);
      int        idx_m;
      sb_entry_t e;
      idx_m = int'(addr % 32);
      wb_bus.i_wb_stb  = 1'b1;
      wb_bus.i_wb_we   = we;
      wb_bus.i_wb_addr = addr;
      wb_bus.i_wb_data = data;
      wb_bus.i_wb_sel  = sel;
      if (we) begin
         if (idx_m != 0) begin
            for (int b = 0; b < 4; b++) begin
               if (sel[b]) mem_m[idx_m][8*b +: 8] = data[8*b +: 8];
            end
         end
      end else begin
         last_rd = (idx_m == 0) ? 32'd0 : mem_m[idx_m];
      end
      e.cyc  = cyc + 32'd1;
      e.data = last_rd;
      e.we   = we;
      e.addr = addr;
      sb_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic wb_idle(input int n);
      wb_bus.i_wb_stb = 1'b0;
      wb_bus.i_wb_we  = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic alu_chk(input string tag, input logic [2:0] op, input logic sub,
                          input logic ars, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      alu_op  = op;
      alu_sub = sub;
      alu_ars = ars;
      alu_a   = a;
      alu_b   = b;
      #1;
      $display("ALU %s op=%03b a=%08h b=%08h y=%08h exp=%08h", tag, op, a, b, alu_y, exp);
      check32(tag, alu_y, exp);
   endtask

   task automatic br_chk(input string tag, input logic [2:0] bop, input logic [31:0] a,
                         input logic [31:0] b, input logic exp);
      br_op = bop;
      alu_a = a;
      alu_b = b;
      #1;
      $display("BR %s op=%03b a=%08h b=%08h taken=%0b exp=%0b", tag, bop, a, b, will_branch, exp);
      check32(tag, {31'b0, will_branch}, {31'b0, exp});
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      cyc     = '0;
      last_rd = '0;
      for (int i = 0; i < 32; i++) mem_m[i] = '0;
      rst     = 1'b1;
      alu_a   = '0;
      alu_b   = '0;
      alu_op  = '0;
      alu_sub = 1'b0;
      alu_ars = 1'b0;
      br_op   = '0;
      wb_bus.i_wb_stb  = 1'b0;
      wb_bus.i_wb_we   = 1'b0;
      wb_bus.i_wb_addr = '0;
      wb_bus.i_wb_data = '0;
      wb_bus.i_wb_sel  = '0;

      // Reset state, with a strobe during reset that must be ignored.
      repeat (2) @(posedge clk);
      #1;
      wb_bus.i_wb_stb = 1'b1;
      @(negedge clk);
      check32("rst_ack", {31'b0, wb_bus.o_wb_ack}, 32'd0);
      check32("rst_data", wb_bus.o_wb_data, 32'd0);
      check32("rst_stall", {31'b0, wb_bus.o_wb_stall}, 32'd0);
      @(posedge clk); #1;
      wb_bus.i_wb_stb = 1'b0;
      rst = 1'b0;

      // Write then read word 5.
      wb_xfer(1'b1, 32'd5, 32'hDEADBEEF, 4'b1111);
      wb_idle(1);
      wb_xfer(1'b0, 32'd5, 32'h0, 4'b0000);
      wb_idle(1);

      // x0 hardwired: write dropped, read returns zero (back-to-back).
      wb_xfer(1'b1, 32'd0, 32'h12345678, 4'b1111);
      wb_xfer(1'b0, 32'd0, 32'h0, 4'b0000);
      wb_idle(1);

      // Byte enables and read-after-write in consecutive transfers.
      wb_xfer(1'b1, 32'd3, 32'hFFFFFFFF, 4'b1111);
      wb_xfer(1'b1, 32'd3, 32'h000000AA, 4'b0001);
      wb_xfer(1'b0, 32'd3, 32'h0, 4'b0000);
      wb_xfer(1'b1, 32'd7, 32'h00000000, 4'b1111);
      wb_xfer(1'b1, 32'd7, 32'hA1B2C3D4, 4'b0110);
      wb_xfer(1'b0, 32'd7, 32'h0, 4'b0000);
      wb_idle(1);

      // Address wrap: 35 maps to word 3.
      wb_xfer(1'b1, 32'd35, 32'h11223344, 4'b1111);
      wb_xfer(1'b0, 32'd3, 32'h0, 4'b0000);
      wb_xfer(1'b0, 32'd35, 32'h0, 4'b0000);
      wb_idle(1);

      // Read word 5 so o_wb_data is nonzero, then reset cancels the next ack.
      wb_xfer(1'b0, 32'd5, 32'h0, 4'b0000);
      wb_bus.i_wb_stb  = 1'b1;
      wb_bus.i_wb_we   = 1'b0;
      wb_bus.i_wb_addr = 32'd3;
      @(posedge clk); #1;
      wb_bus.i_wb_stb = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check32("rst_cancel_ack", {31'b0, wb_bus.o_wb_ack}, 32'd0);
      check32("rst_cancel_data", wb_bus.o_wb_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_rd = 32'd0;
      @(negedge clk);
      check32("post_rst_data", wb_bus.o_wb_data, 32'd0);
      @(posedge clk); #1;
      wb_xfer(1'b0, 32'd5, 32'h0, 4'b0000);
      wb_idle(3);
      check32("sb_drain", 32'(sb_q.size()), 32'd0);

      // ALU
      alu_chk("alu_sub",  3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFFFFFE);
      alu_chk("alu_add",  3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0000000C);
      alu_chk("alu_sra",  3'b101, 1'b0, 1'b1, 32'h80000000, 32'd4, 32'hF8000000);
      alu_chk("alu_srl",  3'b101, 1'b0, 1'b0, 32'h80000000, 32'd4, 32'h08000000);
      alu_chk("alu_sll",  3'b001, 1'b0, 1'b0, 32'h00000001, 32'h00000024, 32'h00000010);
      alu_chk("alu_slt",  3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1);
      alu_chk("alu_sltu", 3'b011, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
      alu_chk("alu_xor",  3'b100, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
      alu_chk("alu_or",   3'b110, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0);
      alu_chk("alu_and",  3'b111, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);

      // Branch
      br_chk("br_lt",    3'b100, 32'hFFFFFFFF, 32'd1, 1'b1);
      br_chk("br_ltu",   3'b110, 32'hFFFFFFFF, 32'd1, 1'b0);
      br_chk("br_ge",    3'b101, 32'hFFFFFFFF, 32'd1, 1'b0);
      br_chk("br_geu",   3'b111, 32'hFFFFFFFF, 32'd1, 1'b1);
      br_chk("br_ne",    3'b001, 32'hFFFFFFFF, 32'd1, 1'b1);
      br_chk("br_eq",    3'b000, 32'hFFFFFFFF, 32'd1, 1'b0);
      br_chk("br_op010", 3'b010, 32'hFFFFFFFF, 32'd1, 1'b0);
      br_chk("br_op011", 3'b011, 32'hFFFFFFFF, 32'd1, 1'b0);
      br_chk("br_eq_t",  3'b000, 32'h00001234, 32'h00001234, 1'b1);
      br_chk("br_ge_eq", 3'b101, 32'h80000000, 32'h80000000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
